// File: rtl/seg_scan_driver_if.sv
// Control/data and display-pin bundle between the host logic and the seven-segment scan driver.
// The master drives scan rate, enable and load data; the slave drives the active-low display pins.
interface seg_scan_driver_if;
  logic        ScanClk;
  logic        Enable;
  logic        Load;
  logic [31:0] Value;
  logic [7:0]  DpMask;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        FrameDone;

  modport master (
    output ScanClk, Enable, Load, Value, DpMask,
    input  An, Seg, Dp, FrameDone
  );

  modport slave (
    input  ScanClk, Enable, Load, Value, DpMask,
    output An, Seg, Dp, FrameDone
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Double-buffered 8-digit hex seven-segment scanner; one ScanClk rising edge advances one digit.
// Pins update one cycle after the index moves; no backpressure, Load is accepted every cycle.
module seg_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  seg_scan_driver_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] DIG_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);

  logic        scan_q;
  logic [2:0]  idx;
  logic [31:0] disp_val;
  logic [7:0]  disp_dp;
  logic [31:0] pend_val;
  logic [7:0]  pend_dp;
  logic        pend_vld;
  logic        wrap_q;

  logic        tick;
  logic        adv;
  logic        wrap;
  logic [3:0]  nib;
  logic        lead_zero;
  logic        blank;

  assign tick = bus.ScanClk & ~scan_q;
  assign adv  = tick & bus.Enable;
  assign wrap = adv & (idx == LAST_IDX);

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant scanned nibble are zero.
  always_comb begin
    nib       = disp_val[{idx, 2'b00} +: 4];
    lead_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (3'(j) >= idx && disp_val[4*j +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
    end
    blank = BLANK_LEADING && (idx != 3'd0) && lead_zero;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      scan_q        <= 1'b1;
      idx           <= 3'd0;
      disp_val      <= 32'h0;
      disp_dp       <= 8'h0;
      pend_val      <= 32'h0;
      pend_dp       <= 8'h0;
      pend_vld      <= 1'b0;
      wrap_q        <= 1'b0;
      bus.An        <= 8'hFF;
      bus.Seg       <= 7'h7F;
      bus.Dp        <= 1'b1;
      bus.FrameDone <= 1'b0;
    end else begin
      scan_q <= bus.ScanClk;
      wrap_q <= wrap;

      if (adv) begin
        idx <= wrap ? 3'd0 : idx + 3'd1;
      end

      // Swap buffers only at the frame boundary so a frame never mixes two values.
      if (bus.Load && wrap) begin
        disp_val <= bus.Value;
        disp_dp  <= bus.DpMask;
        pend_vld <= 1'b0;
      end else begin
        if (wrap && pend_vld) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
          pend_vld <= 1'b0;
        end
        if (bus.Load) begin
          pend_val <= bus.Value;
          pend_dp  <= bus.DpMask;
          pend_vld <= 1'b1;
        end
      end

      if (bus.Enable) begin
        bus.An        <= ~(8'b1 << idx) | ~DIG_MASK;
        bus.Seg       <= blank ? 7'h7F : seg_decode(nib);
        bus.Dp        <= ~disp_dp[idx];
        bus.FrameDone <= wrap_q;
      end else begin
        bus.An        <= 8'hFF;
        bus.Seg       <= 7'h7F;
        bus.Dp        <= 1'b1;
        bus.FrameDone <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a digit-level reference model.
module tb_seg_scan_driver;
  localparam int N = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  seg_scan_driver_if bus();

  seg_scan_driver #(.NUM_DIGITS(N), .BLANK_LEADING(1'b1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: displayed/pending words, digit position, previous ScanClk level.
  int          m_idx;
  logic [31:0] m_val, m_pval;
  logic [7:0]  m_dp, m_pdp;
  bit          m_pvld, m_sq, m_wrap;
  logic [16:0] exp_out;
  logic [16:0] dut_out;

  assign dut_out = {bus.An, bus.Seg, bus.Dp, bus.FrameDone};

  task automatic model_reset();
    m_idx = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0;
    m_pvld = 0; m_sq = 1; m_wrap = 0;
    exp_out = {8'hFF, 7'h7F, 1'b1, 1'b0};
  endtask

  // One clock: predict the pins this edge registers, advance the model, then take the edge.
  task automatic step();
    bit tick, adv, wrap;
    logic [3:0] nib;
    if (bus.Enable) begin
      nib = 4'((m_val >> (4 * m_idx)) & 32'hF);
      exp_out = {~(8'h01 << m_idx),
                 (m_idx != 0 && (m_val >> (4 * m_idx)) == 0) ? 7'h7F : seg_lut[nib],
                 ~m_dp[m_idx], m_wrap};
    end else begin
      exp_out = {8'hFF, 7'h7F, 1'b1, 1'b0};
    end
    tick = bus.ScanClk && !m_sq;
    adv  = tick && bus.Enable;
    wrap = adv && (m_idx == N - 1);
    m_wrap = wrap;
    if (adv) m_idx = (m_idx + 1) % N;
    if (bus.Load && wrap) begin
      m_val = bus.Value; m_dp = bus.DpMask; m_pvld = 0;
    end else begin
      if (wrap && m_pvld) begin
        m_val = m_pval; m_dp = m_pdp; m_pvld = 0;
      end
      if (bus.Load) begin
        m_pval = bus.Value; m_pdp = bus.DpMask; m_pvld = 1;
      end
    end
    m_sq = bus.ScanClk;
    @(posedge Clk);
    #1;
    bus.Load = 1'b0;
  endtask

  task automatic tick_once();
    bus.ScanClk = 1'b1;
    step();
    bus.ScanClk = 1'b0;
    step();
  endtask

  task automatic advance_to(input int target);
    for (int k = 0; k < N && m_idx != target; k++) tick_once();
  endtask

  task automatic test_reset();
    bus.ScanClk = 1'b1; bus.Enable = 1'b1; bus.Load = 1'b0;
    bus.Value = '0; bus.DpMask = '0;
    Rst = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    tests_run++;
    if (dut_out !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected %h", dut_out, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    Rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (dut_out !== {8'hFE, 7'h40, 1'b1, 1'b0}) begin
        tests_failed++; $display("FAIL reset_hold_high: got %h expected %h", dut_out, {8'hFE, 7'h40, 1'b1, 1'b0});
      end
    end
    bus.ScanClk = 1'b0;
    step();
    tick_once();
    tests_run++;
    if (dut_out !== {8'hFD, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL first_tick: got %h expected %h", dut_out, {8'hFD, 7'h7F, 1'b1, 1'b0});
    end
  endtask

  task automatic test_basic_frame();
    int fd_count;
    logic [6:0] want;
    advance_to(N - 1);
    bus.Value = 32'h0000_00A8; bus.DpMask = 8'h00; bus.Load = 1'b1;
    step();
    tick_once();
    tests_run++;
    if (dut_out !== {8'hFE, 7'h00, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL basic_digit0: got %h expected %h", dut_out, {8'hFE, 7'h00, 1'b1, 1'b1});
    end
    fd_count = 0;
    for (int d = 1; d <= N; d++) begin
      bus.ScanClk = 1'b1;
      step();
      fd_count += int'(bus.FrameDone);
      bus.ScanClk = 1'b0;
      step();
      fd_count += int'(bus.FrameDone);
      tests_run++;
      if (dut_out !== exp_out) begin
        tests_failed++; $display("FAIL basic_scan d%0d: got %h expected %h", d, dut_out, exp_out);
      end
      want = (d % N == 0) ? 7'h00 : (d % N == 1) ? 7'h08 : 7'h7F;
      tests_run++;
      if (bus.Seg !== want) begin
        tests_failed++; $display("FAIL basic_seg d%0d: got %h expected %h", d, bus.Seg, want);
      end
    end
    tests_run++;
    if (fd_count != 1) begin
      tests_failed++; $display("FAIL basic_framedone: got %0d pulses expected 1", fd_count);
    end
  endtask

  task automatic test_midframe_load();
    advance_to(3);
    bus.Value = 32'h1234_5678; bus.DpMask = 8'h80; bus.Load = 1'b1;
    step();
    for (int d = 4; d < N; d++) begin
      tick_once();
      tests_run++;
      if (dut_out !== exp_out || bus.Seg !== 7'h7F) begin
        tests_failed++; $display("FAIL mid_old_value d%0d: got %h expected %h", d, dut_out, exp_out);
      end
    end
    tick_once();
    tests_run++;
    if (bus.Seg !== 7'h00 || bus.An !== 8'hFE) begin
      tests_failed++; $display("FAIL mid_new_digit0: got %h expected An=fe Seg=00", dut_out);
    end
    advance_to(N - 1);
    tests_run++;
    if (dut_out !== {8'h7F, 7'h79, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL mid_new_digit7: got %h expected %h", dut_out, {8'h7F, 7'h79, 1'b0, 1'b0});
    end
  endtask

  task automatic test_wrap_load();
    advance_to(4);
    bus.Value = 32'h0000_0005; bus.DpMask = 8'h00; bus.Load = 1'b1;
    step();
    advance_to(N - 1);
    bus.Value = 32'h0000_000F; bus.DpMask = 8'h01; bus.Load = 1'b1;
    bus.ScanClk = 1'b1;
    step();
    bus.ScanClk = 1'b0;
    step();
    tests_run++;
    if (dut_out !== {8'hFE, 7'h0E, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL wrap_load_digit0: got %h expected %h", dut_out, {8'hFE, 7'h0E, 1'b0, 1'b1});
    end
    advance_to(N - 1);
    tick_once();
    tests_run++;
    if (bus.Seg !== 7'h0E) begin
      tests_failed++; $display("FAIL wrap_load_no_stale: got %h expected 0e", bus.Seg);
    end
  endtask

  task automatic test_enable();
    advance_to(5);
    bus.Enable = 1'b0;
    step();
    tests_run++;
    if (dut_out !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL enable_blank: got %h expected %h", dut_out, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    for (int t = 0; t < 3; t++) begin
      tick_once();
      tests_run++;
      if (dut_out !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        tests_failed++; $display("FAIL enable_frozen t%0d: got %h expected %h", t, dut_out, {8'hFF, 7'h7F, 1'b1, 1'b0});
      end
    end
    bus.Enable = 1'b1;
    step();
    tests_run++;
    if (bus.An !== 8'hDF) begin
      tests_failed++; $display("FAIL enable_hold_idx: got An=%h expected df", bus.An);
    end
    tick_once();
    tests_run++;
    if (bus.An !== 8'hBF) begin
      tests_failed++; $display("FAIL enable_resume: got An=%h expected bf", bus.An);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.ScanClk = 1'($urandom_range(0, 1));
      bus.Enable  = ($urandom_range(0, 9) != 0);
      bus.Load    = ($urandom_range(0, 15) == 0);
      bus.Value   = $urandom >> (4 * $urandom_range(0, 8));
      bus.DpMask  = 8'($urandom);
      step();
      tests_run++;
      if (dut_out !== exp_out) begin
        tests_failed++; $display("FAIL random c%0d: got %h expected %h", c, dut_out, exp_out);
      end
    end
    bus.Enable = 1'b1; bus.ScanClk = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bus.Enable = 1'b1; bus.ScanClk = 1'b0;
    advance_to(3);
    #3;
    Rst = 1'b0;
    #1;
    tests_run++;
    if (dut_out !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL async_reset: got %h expected %h", dut_out, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    step();
    tests_run++;
    if (dut_out !== {8'hFE, 7'h40, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL post_reset_digit0: got %h expected %h", dut_out, {8'hFE, 7'h40, 1'b1, 1'b0});
    end
    tick_once();
    tests_run++;
    if (dut_out !== {8'hFD, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL post_reset_digit1: got %h expected %h", dut_out, {8'hFD, 7'h7F, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_midframe_load();
    test_wrap_load();
    test_enable();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
